multicycle_control: RTL
=======================

Name: multicycle_control

Overview:
- Multicycle main controller for the MIPS datapath.
- Sequences each instruction through fetch/decode/execute/memory/writeback states.
- Drives the 3-bit ALU operation select and the datapath enables; consumes the ALU Zero flag to resolve branches.
- Sits between the instruction register (op/funct) and the shared datapath (single ALU, unified memory, register file).

Parameters:
- CNT_W, 32, width of the retired-instruction counter (wraps modulo 2^CNT_W).

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  synchronous active-low reset
- op  input  6  instruction[31:26] from IR, stable from DECODE until the instruction ends
- funct  input  6  instruction[5:0] from IR
- zero  input  1  ALU Zero flag, combinational, same cycle
- pc_en  output  1  PC load enable
- i_or_d  output  1  memory address select: 0=PC, 1=ALUOut
- mem_write  output  1  memory write enable
- ir_write  output  1  IR load enable
- reg_dst  output  1  write-register select: 0=rt, 1=rd
- mem_to_reg  output  1  write-data select: 0=ALUOut, 1=MDR
- reg_write  output  1  register file write enable
- alu_src_a  output  1  0=PC, 1=register A
- alu_src_b  output  2  00=B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
- alu_control  output  3  000 AND, 001 OR, 010 ADD, 100 SUB, 101 MUL, 110 SLT
- pc_src  output  2  00=ALU result, 01=ALUOut, 10=jump target
- illegal_op  output  1  one-cycle pulse: unsupported op/funct was decoded
- state  output  4  current state encoding, for debug
- instr_count  output  CNT_W  retired-instruction count

Behaviour:
- Reset: synchronous; rst_n low at a rising edge sets state=FETCH(0), illegal_op=0, instr_count=0.
- While rst_n is low, pc_en, ir_write, mem_write and reg_write are forced to 0 regardless of state. Reset mid-instruction abandons that instruction; no count.
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11. Codes 12-15 go to FETCH on the next edge.
- Outputs are Moore (decoded from state). Exceptions:
  - pc_en in BRANCH equals zero.
  - alu_control in EXEC is decoded from funct.
  - Unlisted outputs are 0.
- Per-state outputs:
  - FETCH: ir_write=1, pc_en=1, alu_src_b=01, alu_control=010.
  - DECODE: alu_src_b=11, ADD (branch target into ALUOut).
  - MEMADR and ADDIEX: alu_src_a=1, alu_src_b=10, ADD.
  - MEMRD: i_or_d=1.
  - MEMWB: mem_to_reg=1, reg_write=1.
  - MEMWR: i_or_d=1, mem_write=1.
  - EXEC: alu_src_a=1, alu_src_b=00.
  - ALUWB: reg_dst=1, reg_write=1.
  - BRANCH: alu_src_a=1, SUB, pc_src=01.
  - ADDIWB: reg_write=1.
  - JUMP: pc_src=10, pc_en=1.
- Transitions:
  - FETCH->DECODE.
  - DECODE on op:
    - 0x23 (lw) / 0x2B (sw) -> MEMADR
    - 0x00 (R-type) -> EXEC
    - 0x04 (beq) -> BRANCH
    - 0x08 (addi) -> ADDIEX
    - 0x02 (j) -> JUMP
    - anything else -> FETCH
  - MEMADR: lw->MEMRD, sw->MEMWR.
  - MEMRD->MEMWB; EXEC->ALUWB; ADDIEX->ADDIWB.
  - MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB, JUMP -> FETCH.
- Funct decode in EXEC: 0x20->010, 0x22->100, 0x24->000, 0x25->001, 0x2A->110, 0x18->101 (low 32 bits to rd).
- Illegal instructions: an R-type with any other funct goes from DECODE directly to FETCH, like an unsupported op. illegal_op is registered and is 1 for exactly the cycle after that DECODE. No register or memory write occurs and the instruction is not counted.
- Latency in cycles, including FETCH: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- instr_count increments by 1 on each transition from a terminal state to FETCH. It wraps from 2^CNT_W-1 to 0.
- beq not-taken still retires: pc_en=0 in BRANCH, and the count still increments.

Test Plan:
- Reset: hold rst_n=0 for 2 edges in state 7 -> state=0, instr_count=0, illegal_op=0; reg_write=0 while rst_n low.
- lw (op=0x23): state sequence 0,1,2,3,4,0; MEMADR alu_src_b=10/ADD; MEMWB reg_write=1, mem_to_reg=1; instr_count +1 after 5 cycles.
- R-type sweep: funct 0x20,0x22,0x24,0x25,0x2A,0x18 -> EXEC alu_control 010,100,000,001,110,101; ALUWB reg_dst=1, reg_write=1; 4 cycles each.
- beq (op=0x04): with zero=1 -> BRANCH pc_en=1, pc_src=01, alu_control=100; repeat with zero=0 -> pc_en=0. Both take 3 cycles and both increment the count.
- Illegal: op=0x3F, then op=0x00/funct=0x01 -> DECODE->FETCH, illegal_op=1 for one cycle, no mem_write/reg_write, instr_count unchanged.
- Wrap: CNT_W=4, retire 17 j (op=0x02) instructions -> instr_count=1; each j asserts pc_en=1, pc_src=10 in JUMP.

Source files
------------

// File: rtl/multicycle_control.sv
// Multicycle MIPS main controller: sequences fetch/decode/execute/memory/writeback states.
// Latency: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2 cycles; outputs are Moore except noted.
// No backpressure: advances one state every clock; synchronous active-low reset.
module multicycle_control #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             zero,
  output logic             pc_en,
  output logic             i_or_d,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       alu_control,
  output logic [1:0]       pc_src,
  output logic             illegal_op,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    ADDIEX = 4'd9,
    ADDIWB = 4'd10,
    JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b100;
  localparam logic [2:0] ALU_MUL = 3'b101;
  localparam logic [2:0] ALU_SLT = 3'b110;

  state_t cur_state;
  state_t nxt_state;
  logic   illegal_nxt;
  logic   retire;

  // Supported R-type function codes; anything else is treated as illegal at DECODE.
  function automatic logic funct_ok(input logic [5:0] f);
    case (f)
      6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h18: funct_ok = 1'b1;
      default:                                  funct_ok = 1'b0;
    endcase
  endfunction

  // State register; codes 12-15 can only appear via upset and fall back to FETCH in the next-state logic.
  always_ff @(posedge clk) begin
    if (!rst_n) cur_state <= FETCH;
    else        cur_state <= nxt_state;
  end

  // Next-state and Moore output decode; write/load enables are squashed while reset is held.
  always_comb begin
    nxt_state   = FETCH;
    illegal_nxt = 1'b0;
    retire      = 1'b0;
    pc_en       = 1'b0;
    i_or_d      = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    reg_write   = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    alu_control = 3'b000;
    pc_src      = 2'b00;
    case (cur_state)
      FETCH: begin
        ir_write    = 1'b1;
        pc_en       = 1'b1;
        alu_src_b   = 2'b01;
        alu_control = ALU_ADD;
        nxt_state   = DECODE;
      end
      DECODE: begin
        // Branch target is precomputed here so BRANCH only needs the compare.
        alu_src_b   = 2'b11;
        alu_control = ALU_ADD;
        case (op)
          OP_LW, OP_SW: nxt_state = MEMADR;
          OP_RTYPE: begin
            if (funct_ok(funct)) nxt_state = EXEC;
            else                 illegal_nxt = 1'b1;
          end
          OP_BEQ:  nxt_state = BRANCH;
          OP_ADDI: nxt_state = ADDIEX;
          OP_J:    nxt_state = JUMP;
          default: illegal_nxt = 1'b1;
        endcase
      end
      MEMADR: begin
        alu_src_a   = 1'b1;
        alu_src_b   = 2'b10;
        alu_control = ALU_ADD;
        nxt_state   = (op == OP_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        i_or_d    = 1'b1;
        nxt_state = MEMWB;
      end
      MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        retire     = 1'b1;
      end
      MEMWR: begin
        i_or_d    = 1'b1;
        mem_write = 1'b1;
        retire    = 1'b1;
      end
      EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b00;
        case (funct)
          6'h20:   alu_control = ALU_ADD;
          6'h22:   alu_control = ALU_SUB;
          6'h24:   alu_control = ALU_AND;
          6'h25:   alu_control = ALU_OR;
          6'h2A:   alu_control = ALU_SLT;
          6'h18:   alu_control = ALU_MUL;
          default: alu_control = ALU_ADD;
        endcase
        nxt_state = ALUWB;
      end
      ALUWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
        retire    = 1'b1;
      end
      BRANCH: begin
        // Not-taken branches still retire; only the PC load depends on zero.
        alu_src_a   = 1'b1;
        alu_control = ALU_SUB;
        pc_src      = 2'b01;
        pc_en       = zero;
        retire      = 1'b1;
      end
      ADDIEX: begin
        alu_src_a   = 1'b1;
        alu_src_b   = 2'b10;
        alu_control = ALU_ADD;
        nxt_state   = ADDIWB;
      end
      ADDIWB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
      end
      JUMP: begin
        pc_src = 2'b10;
        pc_en  = 1'b1;
        retire = 1'b1;
      end
      default: nxt_state = FETCH;
    endcase
    if (!rst_n) begin
      pc_en     = 1'b0;
      ir_write  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
    end
  end

  // Illegal-op pulse (cycle after DECODE) and retired-instruction counter, wrapping naturally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      illegal_op  <= 1'b0;
      instr_count <= '0;
    end else begin
      illegal_op <= illegal_nxt;
      if (retire) instr_count <= instr_count + CNT_W'(1);
    end
  end

  assign state = cur_state;

endmodule
